// File: rtl/noc_pkg.sv
// Shared constants for the ring NoC: default packet field positions, polarity
// reset value and the ring arbiter owner encoding.
package noc_pkg;

  localparam int NOC_WIDTH  = 64;
  localparam int NOC_VC_BIT = 0;
  localparam int NOC_HOP_HI = 8;
  localparam int NOC_HOP_LO = 15;
  localparam int NUM_VC     = 2;

  localparam logic POL_RESET = 1'b0;

  typedef enum logic {
    OWNER_RING  = 1'b0,
    OWNER_LOCAL = 1'b1
  } owner_e;

  function automatic logic [NUM_VC-1:0] vc_onehot(input logic vc);
    return vc ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/noc_vc_buffer.sv
// One-entry packet buffer with a full flag. A write fills it; a clear empties
// it. The data is left in place on clear because readers gate it with full.
module noc_vc_buffer
  import noc_pkg::*;
#(
  parameter int WIDTH = NOC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [0:WIDTH-1] wr_data,
  input  logic             clr_en,
  output logic             full,
  output logic [0:WIDTH-1] data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (wr_en) begin
      full <= 1'b1;
      data <= wr_data;
    end else if (clr_en) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/ring_router_node.sv
// Single-direction ring router node. Link transfers use VC !polarity while
// buffer moves use VC polarity, so no buffer is read and written in one cycle.
module ring_router_node
  import noc_pkg::*;
#(
  parameter int WIDTH  = NOC_WIDTH,
  parameter int VC_BIT = NOC_VC_BIT,
  parameter int HOP_HI = NOC_HOP_HI,
  parameter int HOP_LO = NOC_HOP_LO
) (
  input  logic             clk,
  input  logic             reset,
  output logic             polarity,
  input  logic             cwsi,
  output logic             cwri,
  input  logic [0:WIDTH-1] cwdi,
  output logic             cwso,
  input  logic             cwro,
  output logic [0:WIDTH-1] cwdo,
  input  logic             pesi,
  output logic             peri,
  input  logic [0:WIDTH-1] pedi,
  output logic             peso,
  input  logic             pero,
  output logic [0:WIDTH-1] pedo
);

  localparam int HOP_W = HOP_LO - HOP_HI + 1;

  if (VC_BIT < 0 || VC_BIT >= WIDTH || HOP_HI > HOP_LO || HOP_LO >= WIDTH) begin : g_bad_fields
    $error("ring_router_node: packet field positions out of range");
  end

  logic              pol_reg;
  owner_e            prio_reg [NUM_VC];
  logic              p_vc, e_vc;
  logic [NUM_VC-1:0] sel_p, sel_e;

  logic [NUM_VC-1:0] ir_full, il_full, or_full, ol_full;
  logic [NUM_VC-1:0] ir_wr, il_wr, or_wr, ol_wr;
  logic [NUM_VC-1:0] ir_clr, il_clr, or_clr, ol_clr;
  logic [0:WIDTH-1]  ir_data [NUM_VC];
  logic [0:WIDTH-1]  il_data [NUM_VC];
  logic [0:WIDTH-1]  or_data [NUM_VC];
  logic [0:WIDTH-1]  ol_data [NUM_VC];

  logic [0:WIDTH-1]  ring_pkt, local_pkt, fwd_pkt, or_wdata;
  logic [HOP_W-1:0]  hop;
  logic              ring_eject, ring_req, local_req, or_free, contend;
  logic              grant_ring, grant_local;

  assign p_vc     = pol_reg;
  assign e_vc     = ~pol_reg;
  assign sel_p    = vc_onehot(p_vc);
  assign sel_e    = vc_onehot(e_vc);
  assign polarity = pol_reg;

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    noc_vc_buffer #(.WIDTH(WIDTH)) u_in_ring (
      .clk(clk), .reset(reset), .wr_en(ir_wr[gi]), .wr_data(cwdi),
      .clr_en(ir_clr[gi]), .full(ir_full[gi]), .data(ir_data[gi])
    );
    noc_vc_buffer #(.WIDTH(WIDTH)) u_in_local (
      .clk(clk), .reset(reset), .wr_en(il_wr[gi]), .wr_data(pedi),
      .clr_en(il_clr[gi]), .full(il_full[gi]), .data(il_data[gi])
    );
    noc_vc_buffer #(.WIDTH(WIDTH)) u_out_ring (
      .clk(clk), .reset(reset), .wr_en(or_wr[gi]), .wr_data(or_wdata),
      .clr_en(or_clr[gi]), .full(or_full[gi]), .data(or_data[gi])
    );
    noc_vc_buffer #(.WIDTH(WIDTH)) u_out_local (
      .clk(clk), .reset(reset), .wr_en(ol_wr[gi]), .wr_data(ring_pkt),
      .clr_en(ol_clr[gi]), .full(ol_full[gi]), .data(ol_data[gi])
    );
  end

  // External phase: link handshakes on VC e.
  assign cwri = ~ir_full[e_vc];
  assign peri = ~il_full[e_vc];
  assign cwso = or_full[e_vc] & cwro;
  assign peso = ol_full[e_vc] & pero;
  assign cwdo = or_full[e_vc] ? or_data[e_vc] : '0;
  assign pedo = ol_full[e_vc] ? ol_data[e_vc] : '0;

  // Internal phase: move packets of VC p from in buffers to out buffers.
  always_comb begin
    ring_pkt                = ir_data[p_vc];
    local_pkt               = il_data[p_vc];
    hop                     = ring_pkt[HOP_HI:HOP_LO];
    fwd_pkt                 = ring_pkt;
    fwd_pkt[HOP_HI:HOP_LO]  = hop - HOP_W'(1);
  end

  assign ring_eject  = ir_full[p_vc] & (hop == '0) & ~ol_full[p_vc];
  assign ring_req    = ir_full[p_vc] & (hop != '0);
  assign local_req   = il_full[p_vc];
  assign or_free     = ~or_full[p_vc];
  assign contend     = ring_req & local_req & or_free;
  assign grant_ring  = or_free & ring_req & (~local_req | (prio_reg[p_vc] == OWNER_RING));
  assign grant_local = or_free & local_req & (~ring_req | (prio_reg[p_vc] == OWNER_LOCAL));
  assign or_wdata    = grant_ring ? fwd_pkt : local_pkt;

  assign ir_wr  = sel_e & {NUM_VC{cwsi & cwri}};
  assign il_wr  = sel_e & {NUM_VC{pesi & peri}};
  assign or_clr = sel_e & {NUM_VC{cwso}};
  assign ol_clr = sel_e & {NUM_VC{peso}};
  assign ir_clr = sel_p & {NUM_VC{ring_eject | grant_ring}};
  assign il_clr = sel_p & {NUM_VC{grant_local}};
  assign or_wr  = sel_p & {NUM_VC{grant_ring | grant_local}};
  assign ol_wr  = sel_p & {NUM_VC{ring_eject}};

  // Priority only flips when both requesters actually compete for a free slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pol_reg     <= POL_RESET;
      prio_reg[0] <= OWNER_RING;
      prio_reg[1] <= OWNER_RING;
    end else begin
      pol_reg <= ~pol_reg;
      if (contend) begin
        prio_reg[p_vc] <= (prio_reg[p_vc] == OWNER_RING) ? OWNER_LOCAL : OWNER_RING;
      end
    end
  end

endmodule

// File: tb/tb_ring_router_node.sv
// Directed bench for ring_router_node: reset, injection, forwarding, ejection,
// arbitration, backpressure and VC independence with hand-computed packets.
module tb_ring_router_node;
    import noc_pkg::*;

    localparam int W = 64;
    localparam logic [0:W-1] ZERO = '0;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         polarity;
    logic         cwsi = 1'b0, cwri, cwso, cwro = 1'b0;
    logic         pesi = 1'b0, peri, peso, pero = 1'b0;
    logic [0:W-1] cwdi = '0, cwdo, pedi = '0, pedo;
    int           errors = 0;
    int           checks = 0;
    logic [0:W-1] pkt_a, pkt_b, s0;

    always #5 clk = ~clk;

    ring_router_node #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .cwsi(cwsi), .cwri(cwri), .cwdi(cwdi), .cwso(cwso), .cwro(cwro), .cwdo(cwdo),
        .pesi(pesi), .peri(peri), .pedi(pedi), .peso(peso), .pero(pero), .pedo(pedo)
    );

    function automatic logic [0:W-1] mk(input logic vc, input logic [7:0] hop, input logic [15:0] pay);
        logic [0:W-1] p;
        p         = '0;
        p[0]      = vc;
        p[8:15]   = hop;
        p[48:63]  = pay;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [0:W-1] obs, input logic [0:W-1] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic align(input logic want);
        for (int i = 0; i < 2 && polarity !== want; i++) tick();
        chk("align_polarity", polarity, want);
    endtask

    initial begin
        #200000;
        errors++;
        $error("FAIL timeout: wait expired before test completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        // Reset state
        repeat (3) tick();
        cwro = 1'b1; pero = 1'b1;
        #1;
        chk("rst_polarity", polarity, 1'b0);
        chk("rst_cwri", cwri, 1'b1);
        chk("rst_peri", peri, 1'b1);
        chk("rst_cwso", cwso, 1'b0);
        chk("rst_peso", peso, 1'b0);
        chk("rst_cwdo", cwdo, ZERO);
        chk("rst_pedo", pedo, ZERO);
        reset = 1'b1;
        tick();
        chk("pol_after_release_1", polarity, 1'b1);
        tick();
        chk("pol_after_release_0", polarity, 1'b0);
        chk("idle_cwri", cwri, 1'b1);
        chk("idle_peri", peri, 1'b1);

        // Injection from the NIC, VC0 hop 3
        align(1'b1);
        pkt_a = mk(1'b0, 8'd3, 16'hABCD);
        pesi = 1'b1; pedi = pkt_a;
        #1;
        chk("inj_peri", peri, 1'b1);
        tick();
        pesi = 1'b0; pedi = '0;
        #1;
        chk("inj_cwso_early", cwso, 1'b0);
        tick();
        chk("inj_cwso", cwso, 1'b1);
        chk("inj_cwdo", cwdo, pkt_a);
        $display("inject: cwdo=%h", cwdo);
        tick();
        tick();
        chk("inj_drained", cwso, 1'b0);

        // Forward, VC1 hop 2 -> hop 1
        align(1'b0);
        pkt_a = mk(1'b1, 8'd2, 16'h1111);
        cwsi = 1'b1; cwdi = pkt_a;
        #1;
        chk("fwd_cwri", cwri, 1'b1);
        tick();
        cwsi = 1'b0; cwdi = '0;
        tick();
        chk("fwd_cwso", cwso, 1'b1);
        chk("fwd_cwdo", cwdo, mk(1'b1, 8'd1, 16'h1111));
        $display("forward: cwdo=%h", cwdo);
        tick();

        // Eject, VC1 hop 0
        align(1'b0);
        pkt_a = mk(1'b1, 8'd0, 16'h2222);
        cwsi = 1'b1; cwdi = pkt_a;
        tick();
        cwsi = 1'b0; cwdi = '0;
        #1;
        chk("ej_peso_early", peso, 1'b0);
        tick();
        chk("ej_peso", peso, 1'b1);
        chk("ej_pedo", pedo, pkt_a);
        chk("ej_cwso", cwso, 1'b0);
        $display("eject: pedo=%h", pedo);
        tick();

        // Contention on out_ring[0]: ring first, then local
        align(1'b1);
        pkt_b = mk(1'b0, 8'd5, 16'h4444);
        cwsi = 1'b1; cwdi = mk(1'b0, 8'd1, 16'h3333);
        pesi = 1'b1; pedi = pkt_b;
        tick();
        cwsi = 1'b0; pesi = 1'b0; cwdi = '0; pedi = '0;
        tick();
        chk("ct1_cwso", cwso, 1'b1);
        chk("ct1_cwdo", cwdo, mk(1'b0, 8'd0, 16'h3333));
        chk("ct1_peri", peri, 1'b0);
        $display("contend1: cwdo=%h", cwdo);
        tick();
        tick();
        chk("ct2_cwso", cwso, 1'b1);
        chk("ct2_cwdo", cwdo, pkt_b);
        $display("contend2: cwdo=%h", cwdo);
        // Second contention: local now holds priority
        pkt_b = mk(1'b0, 8'd7, 16'h6666);
        cwsi = 1'b1; cwdi = mk(1'b0, 8'd1, 16'h5555);
        pesi = 1'b1; pedi = pkt_b;
        tick();
        cwsi = 1'b0; pesi = 1'b0; cwdi = '0; pedi = '0;
        tick();
        chk("ct3_cwdo", cwdo, pkt_b);
        chk("ct3_cwri", cwri, 1'b0);
        $display("contend3: cwdo=%h", cwdo);
        tick();
        tick();
        chk("ct4_cwdo", cwdo, mk(1'b0, 8'd0, 16'h5555));
        $display("contend4: cwdo=%h", cwdo);
        tick();

        // Backpressure on VC1
        align(1'b0);
        cwro = 1'b0;
        cwsi = 1'b1; cwdi = mk(1'b1, 8'd4, 16'h00A1);
        tick();
        cwsi = 1'b0; cwdi = '0;
        tick();
        chk("bp_cwso_hold", cwso, 1'b0);
        chk("bp_cwdo_hold", cwdo, mk(1'b1, 8'd3, 16'h00A1));
        chk("bp_cwri_free", cwri, 1'b1);
        cwsi = 1'b1; cwdi = mk(1'b1, 8'd4, 16'h00A2);
        tick();
        cwsi = 1'b0; cwdi = '0;
        tick();
        chk("bp_cwri_full", cwri, 1'b0);
        chk("bp_cwso_still", cwso, 1'b0);
        cwro = 1'b1;
        #1;
        chk("bp_drain1_cwso", cwso, 1'b1);
        chk("bp_drain1_cwdo", cwdo, mk(1'b1, 8'd3, 16'h00A1));
        $display("backpressure drain1: cwdo=%h", cwdo);
        tick();
        tick();
        chk("bp_drain2_cwso", cwso, 1'b1);
        chk("bp_drain2_cwdo", cwdo, mk(1'b1, 8'd3, 16'h00A2));
        chk("bp_drain2_cwri", cwri, 1'b1);
        $display("backpressure drain2: cwdo=%h", cwdo);
        tick();

        // VC independence: VC0 stalled, VC1 streams every other cycle
        align(1'b1);
        cwro = 1'b0;
        s0 = mk(1'b0, 8'd2, 16'h00B0);
        pesi = 1'b1; pedi = s0;
        tick();
        pesi = 1'b0; pedi = '0;
        for (int k = 0; k < 3; k++) begin
            cwro = 1'b1;
            cwsi = 1'b1; cwdi = mk(1'b1, 8'd1, 16'(16'h00C0 + k));
            #1;
            if (k > 0) begin
                chk("vc1_cwso", cwso, 1'b1);
                chk("vc1_cwdo", cwdo, mk(1'b1, 8'd0, 16'(16'h00C0 + k - 1)));
                $display("vc1 stream %0d: cwdo=%h", k - 1, cwdo);
            end
            tick();
            cwsi = 1'b0; cwdi = '0; cwro = 1'b0;
            #1;
            chk("vc0_stall_cwso", cwso, 1'b0);
            chk("vc0_stall_cwdo", cwdo, s0);
            tick();
        end
        cwro = 1'b1;
        #1;
        chk("vc1_last_cwdo", cwdo, mk(1'b1, 8'd0, 16'h00C2));
        tick();
        chk("vc0_release_cwso", cwso, 1'b1);
        chk("vc0_release_cwdo", cwdo, s0);
        $display("vc0 release: cwdo=%h", cwdo);

        // Asynchronous reset in the middle of traffic
        cwro = 1'b0;
        pesi = 1'b1; pedi = mk(1'b0, 8'd1, 16'hD0D0);
        tick();
        pesi = 1'b0; pedi = '0;
        tick();
        cwro = 1'b1;
        #1;
        chk("rst_pre_cwso", cwso, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_polarity", polarity, 1'b0);
        chk("arst_cwso", cwso, 1'b0);
        chk("arst_cwdo", cwdo, ZERO);
        chk("arst_cwri", cwri, 1'b1);
        chk("arst_peri", peri, 1'b1);
        chk("arst_peso", peso, 1'b0);
        chk("arst_pedo", pedo, ZERO);
        tick();
        chk("arst_hold_polarity", polarity, 1'b0);
        reset = 1'b1;
        tick();
        chk("rerelease_pol_1", polarity, 1'b1);
        chk("rerelease_cwso", cwso, 1'b0);
        tick();
        chk("rerelease_pol_0", polarity, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
